// File: rtl/neopixel_rx_decoder.sv
// neopixel_rx_decoder: measures NeoPixel high pulses, assembles 24-bit pixels, detects the inter-frame reset low.
module neopixel_rx_decoder #(
    parameter int PIXELS_MAX     = 3,
    parameter int PIXELS_BITS    = 2,
    parameter int ONE_THRESHOLD  = 6,
    parameter int MAX_HIGH_TICKS = 11,
    parameter int RESET_TICKS    = 400
) (
    input  logic                   CLK_10MHZ,
    input  logic                   RESET_N,
    input  logic                   NEO_DATA,
    output logic [23:0]            PIXEL_VALUE,
    output logic [PIXELS_BITS-1:0] PIXEL_INDEX,
    output logic                   PIXEL_VALID,
    output logic                   FRAME_DONE,
    output logic [PIXELS_BITS-1:0] FRAME_PIXELS,
    output logic                   ERR_TIMING,
    output logic                   ERR_PARTIAL,
    output logic                   ERR_OVERFLOW,
    output logic [1:0]             VERBOSE_STATE
);
    typedef enum logic [1:0] {SYNC = 2'd0, IDLE = 2'd1, HIGH = 2'd2, LOW = 2'd3} state_t;

    localparam logic [3:0]             H_LAST = 4'(MAX_HIGH_TICKS - 1);
    localparam logic [3:0]             H_ONE  = 4'(ONE_THRESHOLD);
    localparam logic [8:0]             L_LAST = 9'(RESET_TICKS - 1);
    localparam logic [PIXELS_BITS-1:0] P_MAX  = PIXELS_BITS'(PIXELS_MAX);

    state_t                 state;
    logic                   s1, s2, s3;
    logic [8:0]             low_cnt;
    logic [3:0]             high_cnt;
    logic [4:0]             bit_idx;
    logic [PIXELS_BITS-1:0] pix_idx;
    logic [23:0]            shreg;
    logic                   px_done;
    logic                   rise;

    assign rise          = s2 & ~s3;
    assign VERBOSE_STATE = state;

    always_ff @(posedge CLK_10MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            {s3, s2, s1} <= 3'b000;
            state        <= SYNC;
            low_cnt      <= '0;
            high_cnt     <= '0;
            bit_idx      <= '0;
            pix_idx      <= '0;
            shreg        <= '0;
            px_done      <= 1'b0;
            PIXEL_VALUE  <= '0;
            PIXEL_INDEX  <= '0;
            PIXEL_VALID  <= 1'b0;
            FRAME_DONE   <= 1'b0;
            FRAME_PIXELS <= '0;
            ERR_TIMING   <= 1'b0;
            ERR_PARTIAL  <= 1'b0;
            ERR_OVERFLOW <= 1'b0;
        end else begin
            {s3, s2, s1} <= {s2, s1, NEO_DATA};
            PIXEL_VALID  <= 1'b0;
            FRAME_DONE   <= 1'b0;
            ERR_TIMING   <= 1'b0;
            ERR_PARTIAL  <= 1'b0;
            ERR_OVERFLOW <= 1'b0;
            px_done      <= 1'b0;
            // publish one cycle after the 24th bit lands; pix_idx saturates at PIXELS_MAX
            if (px_done) begin
                if (pix_idx == P_MAX) begin
                    ERR_OVERFLOW <= 1'b1;
                end else begin
                    PIXEL_VALID <= 1'b1;
                    PIXEL_VALUE <= shreg;
                    PIXEL_INDEX <= pix_idx;
                    pix_idx     <= pix_idx + 1'b1;
                end
            end
            case (state)
                SYNC: begin
                    if (s2) begin
                        low_cnt <= '0;
                    end else if (low_cnt == L_LAST) begin
                        low_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        low_cnt <= low_cnt + 9'd1;
                    end
                end
                IDLE: begin
                    if (rise) begin
                        state    <= HIGH;
                        high_cnt <= 4'd1;
                        bit_idx  <= '0;
                        pix_idx  <= '0;
                    end
                end
                HIGH: begin
                    if (s2) begin
                        if (high_cnt == H_LAST) begin
                            ERR_TIMING <= 1'b1;
                            state      <= SYNC;
                            low_cnt    <= '0;
                            bit_idx    <= '0;
                            pix_idx    <= '0;
                        end else begin
                            high_cnt <= high_cnt + 4'd1;
                        end
                    end else begin
                        shreg[bit_idx] <= (high_cnt >= H_ONE);
                        state          <= LOW;
                        low_cnt        <= 9'd1;
                        bit_idx        <= (bit_idx == 5'd23) ? 5'd0 : bit_idx + 5'd1;
                        px_done        <= (bit_idx == 5'd23);
                    end
                end
                LOW: begin
                    if (s2) begin
                        state    <= HIGH;
                        high_cnt <= 4'd1;
                    end else if (low_cnt == L_LAST) begin
                        FRAME_DONE   <= 1'b1;
                        FRAME_PIXELS <= pix_idx;
                        ERR_PARTIAL  <= (bit_idx != 5'd0);
                        bit_idx      <= '0;
                        state        <= IDLE;
                    end else begin
                        low_cnt <= low_cnt + 9'd1;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_neopixel_rx_decoder.sv
// tb_neopixel_rx_decoder: pulse-level reference model with an event scoreboard checked on every clock.
module tb_neopixel_rx_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic [23:0] pixel_value;
    logic [1:0]  pixel_index;
    logic        pixel_valid;
    logic        frame_done;
    logic [1:0]  frame_pixels;
    logic        err_timing;
    logic        err_partial;
    logic        err_overflow;
    logic [1:0]  verbose_state;

    always #50 clk = ~clk;

    neopixel_rx_decoder dut (
        .CLK_10MHZ    (clk),
        .RESET_N      (rst_n),
        .NEO_DATA     (din),
        .PIXEL_VALUE  (pixel_value),
        .PIXEL_INDEX  (pixel_index),
        .PIXEL_VALID  (pixel_valid),
        .FRAME_DONE   (frame_done),
        .FRAME_PIXELS (frame_pixels),
        .ERR_TIMING   (err_timing),
        .ERR_PARTIAL  (err_partial),
        .ERR_OVERFLOW (err_overflow),
        .VERBOSE_STATE(verbose_state)
    );

    // strobe vector order: {valid, frame_done, err_timing, err_partial, err_overflow}
    typedef struct {
        logic [4:0]  stb;
        logic [23:0] val;
        logic [1:0]  idx;
        logic [1:0]  fp;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         cur;
    int          errs = 0;
    int          checks = 0;
    logic [23:0] last_val;
    logic [1:0]  last_idx;
    int          n_pv = 0, n_ov = 0, n_te = 0, n_fd = 0;
    logic        cap_ep = 1'b0;
    logic [23:0] pv_log[$];
    int          idx_log[$];
    int          fp_log[$];

    // model: mode 0 = unsynchronised, 1 = between frames, 2 = inside a frame
    int          mode, low_run, bits, pix, ph;
    logic [23:0] word;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic void push(input logic [4:0] stb, input logic [23:0] val, input int idx, input int fp);
        ev_t e;
        e.stb = stb;
        e.val = val;
        e.idx = 2'(idx);
        e.fp  = 2'(fp);
        exp_q.push_back(e);
    endfunction

    task automatic model_high(input int h);
        if (mode == 0) begin
            low_run = 0;
        end else begin
            if (mode == 1) begin
                pix  = 0;
                bits = 0;
            end
            if (h >= 11) begin
                push(5'b00100, 0, 0, 0);
                mode    = 0;
                low_run = 0;
            end else begin
                ph   = h;
                mode = 2;
            end
        end
    endtask

    task automatic model_low(input int n);
        if (mode == 0) begin
            low_run += n;
            if (low_run >= 400) mode = 1;
        end else if (mode == 2) begin
            word[bits] = (ph >= 6);
            bits++;
            if (bits == 24) begin
                bits = 0;
                if (pix == 3) push(5'b00001, 0, 0, 0);
                else begin
                    push(5'b10000, word, pix, 0);
                    pix++;
                end
            end
            if (n >= 400) begin
                push({1'b0, 1'b1, 1'b0, bits != 0, 1'b0}, 0, 0, pix);
                bits = 0;
                mode = 1;
            end
        end
    endtask

    task automatic drive(input logic v, input int n);
        #1 din = v;
        repeat (n) @(posedge clk);
    endtask

    task automatic pulse(input int h, input int l);
        model_high(h);
        drive(1'b1, h);
        model_low(l);
        drive(1'b0, l);
    endtask

    task automatic send_word(input logic [23:0] v, input int endlow);
        for (int i = 0; i < 24; i++)
            pulse(v[i] ? 8 : 3, (i == 23 && endlow > 0) ? endlow : (v[i] ? 4 : 9));
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
    endtask

    task automatic model_reset();
        mode    = 0;
        low_run = 0;
        bits    = 0;
        pix     = 0;
        word    = '0;
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {pixel_value, pixel_index, pixel_valid, frame_done, frame_pixels,
                                    err_timing, err_partial, err_overflow, verbose_state}, 64'd0);
            last_val = '0;
            last_idx = '0;
        end else begin
            if ({pixel_valid, frame_done, err_timing, err_partial, err_overflow} != 5'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {pixel_valid, frame_done, err_timing, err_partial, err_overflow}, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("strobes", {pixel_valid, frame_done, err_timing, err_partial, err_overflow}, cur.stb);
                    if (cur.stb[4]) begin
                        last_val = cur.val;
                        last_idx = cur.idx;
                    end
                    if (cur.stb[3]) check("frame_pixels", frame_pixels, cur.fp);
                end
                if (pixel_valid) begin
                    n_pv++;
                    pv_log.push_back(pixel_value);
                    idx_log.push_back(int'(pixel_index));
                end
                if (frame_done) begin
                    n_fd++;
                    fp_log.push_back(int'(frame_pixels));
                    cap_ep = err_partial;
                end
                if (err_overflow) n_ov++;
                if (err_timing) n_te++;
            end
            check("pixel_value", pixel_value, last_val);
            check("pixel_index", pixel_index, last_idx);
        end
    end

    initial begin
        int b0, nb, bit_v, h, pv0, fd0, te0, ov0, lg0, fg0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // single pixel frame
        pulse(0, 0);
        model_low(400);
        drive(1'b0, 400);
        pv0 = n_pv; fd0 = n_fd; lg0 = pv_log.size();
        send_word(24'hff00d5, 500);
        settle();
        check("t1_pv_count", n_pv - pv0, 1);
        check("t1_value", pv_log[lg0], 24'hff00d5);
        check("t1_index", idx_log[lg0], 0);
        check("t1_frame_pixels", fp_log[fd0], 1);
        check("t1_no_partial", cap_ep, 0);

        // two frames of three pixels
        lg0 = pv_log.size(); fg0 = fp_log.size();
        repeat (2) begin
            send_word(24'hff00d5, 0);
            send_word(24'h008800, 0);
            send_word(24'h000090, 450);
        end
        settle();
        for (int i = 0; i < 6; i++) check("t2_index", idx_log[lg0 + i], i % 3);
        check("t2_value2", pv_log[lg0 + 5], 24'h000090);
        check("t2_fp0", fp_log[fg0], 3);
        check("t2_fp1", fp_log[fg0 + 1], 3);

        // threshold: 5-tick highs decode 0, 6-tick highs decode 1
        lg0 = pv_log.size();
        for (int i = 0; i < 24; i++) pulse(5, 9);
        for (int i = 0; i < 24; i++) pulse(6, i == 23 ? 450 : 4);
        settle();
        check("t3_zero", pv_log[lg0], 24'h000000);
        check("t3_ones", pv_log[lg0 + 1], 24'hffffff);

        // partial frame
        pv0 = n_pv; fd0 = n_fd;
        for (int i = 0; i < 10; i++) pulse(8, i == 9 ? 400 : 4);
        settle();
        check("t4_no_pv", n_pv - pv0, 0);
        check("t4_fp", fp_log[fd0], 0);
        check("t4_partial", cap_ep, 1);

        // timing error, short low ignored, then resync
        te0 = n_te; pv0 = n_pv; lg0 = pv_log.size();
        pulse(11, 200);
        check("t5_te", n_te - te0, 1);
        check("t5_state_sync", verbose_state, 0);
        send_word(24'h123456, 400);
        send_word(24'hff00d5, 450);
        settle();
        check("t5_pv_count", n_pv - pv0, 1);
        check("t5_value", pv_log[lg0], 24'hff00d5);

        // overflow on the fourth pixel
        pv0 = n_pv; ov0 = n_ov; fd0 = n_fd;
        send_word(24'h000001, 0);
        send_word(24'h000002, 0);
        send_word(24'h000003, 0);
        send_word(24'h000004, 450);
        settle();
        check("t6_pv_count", n_pv - pv0, 3);
        check("t6_ov", n_ov - ov0, 1);
        check("t6_fp", fp_log[fd0], 3);

        // reset mid-pixel
        for (int i = 0; i < 5; i++) pulse(8, 4);
        drive(1'b1, 2);
        #20 rst_n = 1'b0;
        #1 check("t7_state", verbose_state, 0);
        check("t7_outputs", {pixel_value, pixel_index, frame_pixels}, 0);
        model_reset();
        drive(1'b0, 3);
        #1 rst_n = 1'b1;
        pv0 = n_pv;
        for (int i = 0; i < 10; i++) pulse(8, 4);
        settle();
        check("t7_ignored", n_pv - pv0, 0);
        pulse(0, 0);
        model_low(450);
        drive(1'b0, 450);

        // randomized frames
        for (int f = 0; f < 20; f++) begin
            nb = $urandom_range(1, 80);
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 59) == 0) begin
                    pulse(11 + $urandom_range(0, 3), 450);
                end else begin
                    bit_v = $urandom_range(0, 1);
                    h = bit_v ? $urandom_range(6, 10) : $urandom_range(1, 5);
                    pulse(h, (i == nb - 1) ? $urandom_range(400, 480) : $urandom_range(1, 10));
                end
            end
        end
        b0 = 0;
        drive(1'b0, 20);
        check("drain", exp_q.size(), b0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
